// File: rtl/aes_byte_loader_pkg.sv
// Shared constants and the loader state type for the AES byte-serial front end.
package aes_byte_loader_pkg;

    localparam int unsigned AES_BLK_BYTES = 16;
    localparam int unsigned AES_BW        = 8;
    localparam int unsigned AES_BLK_W     = AES_BLK_BYTES * AES_BW;
    localparam int unsigned AES_CNT_W     = $clog2(AES_BLK_BYTES);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        OFFER = 2'd1,
        DRAIN = 2'd2
    } loader_state_e;

endpackage

// File: rtl/aes_byte_loader_if.sv
// Byte input side and block output side of the AES loader.
// master: byte source plus round core; slave: the loader itself.
interface aes_byte_loader_if;
    import aes_byte_loader_pkg::*;

    logic                 valid;
    logic [AES_BW-1:0]    PT;
    logic [AES_BW-1:0]    KEY;
    logic                 ready;
    logic                 blk_valid;
    logic                 blk_ready;
    logic                 core_done;
    logic [AES_BLK_W-1:0] pt_blk;
    logic [AES_BLK_W-1:0] key_blk;
    logic                 overrun;

    modport master (
        output valid, PT, KEY, blk_ready, core_done,
        input  ready, blk_valid, pt_blk, key_blk, overrun
    );

    modport slave (
        input  valid, PT, KEY, blk_ready, core_done,
        output ready, blk_valid, pt_blk, key_blk, overrun
    );

endinterface

// File: rtl/aes_byte_shreg.sv
// NBYTES x BW shift register; new bytes enter at the LSB end so the first byte ends up at the MSB.
module aes_byte_shreg #(
    parameter int unsigned NBYTES = 16,
    parameter int unsigned BW     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [BW-1:0]        din,
    output logic [NBYTES*BW-1:0] dout
);

    logic [NBYTES*BW-1:0] data_q;

    // Shift one byte in per enabled edge; async clear discards any partial block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (en) begin
            data_q <= {data_q[NBYTES*BW-BW-1:0], din};
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/aes_byte_loader.sv
// Collects 16 PT/KEY byte pairs into 128-bit blocks, offers them to the round core and
// blocks further input until the core signals that the block's ciphertext is out.
module aes_byte_loader
    import aes_byte_loader_pkg::*;
(
    input logic              clk,
    input logic              reset,
    aes_byte_loader_if.slave bus
);

    localparam logic [AES_CNT_W-1:0] CNT_LAST = AES_CNT_W'(AES_BLK_BYTES - 1);

    loader_state_e        state_q, state_d;
    logic [AES_CNT_W-1:0] cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 blk_valid_q, blk_valid_d;
    logic                 overrun_q, overrun_d;
    logic                 shift_en;

    // State, counter and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            blk_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            blk_valid_q <= blk_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic; ready and blk_valid are computed one edge ahead so the outputs are registered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        blk_valid_d = blk_valid_q;
        shift_en    = 1'b0;
        // A byte offered while not ready is dropped and remembered until reset.
        overrun_d   = overrun_q | (bus.valid & ~ready_q);

        case (state_q)
            FILL: begin
                ready_d = 1'b1;
                if (bus.valid && ready_q) begin
                    shift_en = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d       = '0;
                        ready_d     = 1'b0;
                        blk_valid_d = 1'b1;
                        state_d     = OFFER;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OFFER: begin
                ready_d     = 1'b0;
                blk_valid_d = 1'b1;
                if (bus.blk_ready) begin
                    blk_valid_d = 1'b0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                ready_d     = 1'b0;
                blk_valid_d = 1'b0;
                if (bus.core_done) begin
                    ready_d = 1'b1;
                    state_d = FILL;
                end
            end
            default: begin
                state_d     = FILL;
                cnt_d       = '0;
                ready_d     = 1'b0;
                blk_valid_d = 1'b0;
            end
        endcase
    end

    aes_byte_shreg #(
        .NBYTES (AES_BLK_BYTES),
        .BW     (AES_BW)
    ) u_pt_shreg (
        .clk   (clk),
        .reset (reset),
        .en    (shift_en),
        .din   (bus.PT),
        .dout  (bus.pt_blk)
    );

    aes_byte_shreg #(
        .NBYTES (AES_BLK_BYTES),
        .BW     (AES_BW)
    ) u_key_shreg (
        .clk   (clk),
        .reset (reset),
        .en    (shift_en),
        .din   (bus.KEY),
        .dout  (bus.key_blk)
    );

    assign bus.ready     = ready_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_aes_byte_loader.sv
// Bench for aes_byte_loader: directed FIPS-197 streams plus randomized blocks; expected blocks
// are queued by the stimulus and checked by a monitor at the block handshake.
module tb_aes_byte_loader;
    import aes_byte_loader_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    aes_byte_loader_if bus ();

    aes_byte_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
    } blk_t;

    blk_t         exp_q[$];
    int           n_total = 0;
    int           n_pass  = 0;
    logic [127:0] last_pt  = '0;
    logic [127:0] last_key = '0;
    logic         exp_ovr  = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: the first byte of the stream is the most significant byte of the block.
    function automatic logic [127:0] pack(input logic [7:0] b[16]);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v = v * 256 + 128'(b[i]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams 16 byte pairs; optional idle gap after byte index gap_at.
    task automatic send_block(input logic [7:0] pt[16], input logic [7:0] key[16],
                              input int gap_at, input int gap_len, input bit early_rdy);
        blk_t b;
        b.pt  = pack(pt);
        b.key = pack(key);
        exp_q.push_back(b);
        for (int i = 0; i < 16; i++) begin
            chk1("ready_in_fill", bus.ready, 1'b1);
            chk1("blk_valid_low_in_fill", bus.blk_valid, 1'b0);
            bus.valid = 1'b1;
            bus.PT    = pt[i];
            bus.KEY   = key[i];
            if (i == 15 && early_rdy) bus.blk_ready = 1'b1;
            tick();
            bus.valid = 1'b0;
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    chk1("ready_during_gap", bus.ready, 1'b1);
                    chk1("blk_valid_low_during_gap", bus.blk_valid, 1'b0);
                end
            end
        end
        chk1("blk_valid_latency", bus.blk_valid, 1'b1);
        chk1("ready_low_after_block", bus.ready, 1'b0);
        last_pt  = b.pt;
        last_key = b.key;
    endtask

    // Holds the offer, completes the handshake, sits in drain, then releases with core_done.
    task automatic offer_and_drain(input int hold, input bit early, input bit done_in_offer,
                                   input bit poke_aa);
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                if (done_in_offer && i == 1) bus.core_done = 1'b1;
                tick();
                bus.core_done = 1'b0;
                chk1("offer_blk_valid_held", bus.blk_valid, 1'b1);
                chk1("offer_ready_low", bus.ready, 1'b0);
                chk128("offer_pt_frozen", bus.pt_blk, last_pt);
                chk128("offer_key_frozen", bus.key_blk, last_key);
            end
            bus.blk_ready = 1'b1;
        end
        tick();
        bus.blk_ready = 1'b0;
        chk1("blk_valid_drop_after_handshake", bus.blk_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (poke_aa && i == 1) begin
                bus.valid = 1'b1;
                bus.PT    = 8'hAA;
                bus.KEY   = 8'hAA;
                exp_ovr   = 1'b1;
            end
            tick();
            bus.valid = 1'b0;
            chk1("drain_ready_low", bus.ready, 1'b0);
            chk1("drain_blk_valid_low", bus.blk_valid, 1'b0);
            chk128("drain_pt_held", bus.pt_blk, last_pt);
            chk128("drain_key_held", bus.key_blk, last_key);
        end
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        chk1("ready_after_core_done", bus.ready, 1'b1);
        chk1("overrun_flag", bus.overrun, exp_ovr);
    endtask

    // Monitor: a block handshake is seen at the falling edge before the accepting rising edge.
    initial begin
        blk_t b;
        forever begin
            @(negedge clk);
            if (!reset && bus.blk_valid && bus.blk_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_block: got pt %h, expected no block", bus.pt_blk);
                end else begin
                    b = exp_q.pop_front();
                    chk128("pt_blk", bus.pt_blk, b.pt);
                    chk128("key_blk", bus.key_blk, b.key);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        logic [7:0] fpt[16];
        logic [7:0] fkey[16];
        logic [7:0] rpt[16];
        logic [7:0] rkey[16];
        bit         early;

        bus.valid     = 1'b0;
        bus.PT        = '0;
        bus.KEY       = '0;
        bus.blk_ready = 1'b0;
        bus.core_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fpt[i]  = 8'(i * 17);
            fkey[i] = 8'(i);
        end

        #10 reset = 1'b1;
        #10;
        chk1("reset_ready", bus.ready, 1'b0);
        chk1("reset_blk_valid", bus.blk_valid, 1'b0);
        chk128("reset_pt_blk", bus.pt_blk, '0);
        chk128("reset_key_blk", bus.key_blk, '0);
        chk1("reset_overrun", bus.overrun, 1'b0);
        #10 reset = 1'b0;
        #1;
        chk1("ready_before_first_edge", bus.ready, 1'b0);
        tick();

        // FIPS-197 vector, back to back.
        send_block(fpt, fkey, -1, 0, 1'b0);
        offer_and_drain(2, 1'b0, 1'b0, 1'b0);

        // Same vector with a 3-cycle valid gap after byte 7.
        send_block(fpt, fkey, 6, 3, 1'b0);
        offer_and_drain(2, 1'b0, 1'b0, 1'b0);

        // Long offer hold.
        send_block(fpt, fkey, -1, 0, 1'b0);
        offer_and_drain(5, 1'b0, 1'b0, 1'b0);

        // Byte poked during drain, then a second block.
        send_block(fpt, fkey, -1, 0, 1'b0);
        offer_and_drain(1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            rpt[i]  = 8'($urandom);
            rkey[i] = 8'($urandom);
        end
        send_block(rpt, rkey, -1, 0, 1'b0);
        offer_and_drain(1, 1'b0, 1'b0, 1'b0);

        // core_done pulsed while the block is still on offer.
        send_block(fpt, fkey, -1, 0, 1'b0);
        offer_and_drain(4, 1'b0, 1'b1, 1'b0);

        // Reset after 9 bytes of a partial block.
        for (int i = 0; i < 9; i++) begin
            bus.valid = 1'b1;
            bus.PT    = rpt[i];
            bus.KEY   = rkey[i];
            tick();
        end
        bus.valid = 1'b0;
        #2 reset  = 1'b1;
        #1;
        chk1("midreset_ready", bus.ready, 1'b0);
        chk1("midreset_blk_valid", bus.blk_valid, 1'b0);
        chk128("midreset_pt_blk", bus.pt_blk, '0);
        chk128("midreset_key_blk", bus.key_blk, '0);
        chk1("midreset_overrun", bus.overrun, 1'b0);
        exp_ovr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        send_block(fpt, fkey, -1, 0, 1'b0);
        offer_and_drain(1, 1'b0, 1'b0, 1'b0);

        // Randomized blocks with random gaps, holds and early blk_ready.
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 16; i++) begin
                rpt[i]  = 8'($urandom);
                rkey[i] = 8'($urandom);
            end
            early = 1'($urandom_range(0, 1));
            send_block(rpt, rkey, int'($urandom_range(0, 14)), int'($urandom_range(0, 3)), early);
            offer_and_drain(int'($urandom_range(0, 3)), early, 1'b0, 1'b0);
        end

        repeat (2) tick();
        chk128("scoreboard_empty", 128'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
